// File: rtl/spi_slave_apb_pkg.sv
// Shared types and constants for the APB memory target.
package spi_slave_apb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} apb_tgt_state_e;

  localparam int MAX_WAIT_CYCLES = 255;
  localparam int COUNT_W         = 16;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/spi_slave_apb_mem_target_if.sv
// APB bus bundle between the SPI-side master plug and the memory target.
interface spi_slave_apb_mem_target_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          psel;
  logic          penable;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  modport master (output psel, penable, paddr, pwrite, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, paddr, pwrite, pwdata,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/spi_slave_apb_mem_array.sv
// Single-port synchronous RAM with registered read data (read-first).
module spi_slave_apb_mem_array #(
  parameter int DEPTH = 256,
  parameter int DW    = 32,
  parameter int MAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic           clk_i,
  input  logic           we_i,
  input  logic [MAW-1:0] addr_i,
  input  logic [DW-1:0]  wdata_i,
  output logic [DW-1:0]  rdata_o
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[addr_i] <= wdata_i;
    rdata_o <= mem[addr_i];
  end
endmodule

// File: rtl/spi_slave_apb_mem_target.sv
// APB completer backed by a word-addressed RAM, with optional wait states,
// range errors, a sticky protocol-violation flag and saturating access counters.
module spi_slave_apb_mem_target
  import spi_slave_apb_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int DEPTH          = 256,
  parameter int WAIT_CYCLES    = 0
) (
  input  logic                       pclk_i,
  input  logic                       preset_i,
  spi_slave_apb_mem_target_if.slave  apb,
  output logic                       proto_err_o,
  output logic [COUNT_W-1:0]         wr_count_o,
  output logic [COUNT_W-1:0]         rd_count_o
);
  localparam int AW  = APB_ADDR_WIDTH;
  localparam int DW  = APB_DATA_WIDTH;
  localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] WAIT_INIT =
    8'((WAIT_CYCLES > MAX_WAIT_CYCLES) ? MAX_WAIT_CYCLES : WAIT_CYCLES);

  apb_tgt_state_e     state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic               write_q, write_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic               range_q, range_d;
  logic               proto_q, proto_d;
  logic [COUNT_W-1:0] wr_q, wr_d, rd_q, rd_d;

  logic               mem_we;
  logic [MAW-1:0]     mem_addr;
  logic [DW-1:0]      mem_rdata;
  logic               viol;
  logic [DW-1:0]      prdata;
  logic               pready, pslverr;

  spi_slave_apb_mem_array #(.DEPTH(DEPTH), .DW(DW), .MAW(MAW)) u_mem (
    .clk_i   (pclk_i),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

  // Once a transfer is latched the master must hold every phase signal steady.
  assign viol = !(apb.psel && apb.penable) || (apb.paddr != addr_q) ||
                (apb.pwrite != write_q) || (apb.pwdata != wdata_q);

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      range_q <= 1'b0;
      proto_q <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      range_q <= range_d;
      proto_q <= proto_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    range_d  = range_q;
    proto_d  = proto_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    mem_we   = 1'b0;
    mem_addr = apb.paddr[MAW-1:0];
    pready   = 1'b0;
    pslverr  = 1'b0;
    prdata   = '0;
    case (state_q)
      IDLE: begin
        if (apb.psel && !apb.penable) begin
          addr_d  = apb.paddr;
          write_d = apb.pwrite;
          wdata_d = apb.pwdata;
          range_d = (apb.paddr >= AW'(DEPTH));
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
        end else if (apb.psel && apb.penable) begin
          proto_d = 1'b1;
        end
      end
      WAIT: begin
        mem_addr = addr_q[MAW-1:0];
        if (viol) begin
          proto_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_addr = addr_q[MAW-1:0];
        pready   = 1'b1;
        pslverr  = range_q;
        prdata   = (!write_q && !range_q) ? mem_rdata : '0;
        state_d  = IDLE;
        if (viol) begin
          proto_d = 1'b1;
        end else if (!range_q) begin
          // Reset in the same cycle must drop the commit.
          if (write_q) begin
            mem_we = !preset_i;
            wr_d   = sat_inc(wr_q);
          end else begin
            rd_d   = sat_inc(rd_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign apb.prdata  = prdata;
  assign apb.pready  = pready;
  assign apb.pslverr = pslverr;
  assign proto_err_o = proto_q;
  assign wr_count_o  = wr_q;
  assign rd_count_o  = rd_q;
endmodule
